// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/handshake stage: edge-detects raw requests into sticky
// pending bits, exposes them (masked) to an external priority encoder and
// runs an irq/ack handshake with acknowledge timeout.

module irq_pending_line (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic clr_i,
  output logic pending_o
);
  logic req_q;
  logic pending_q, pending_d;

  // A fresh rise wins over a same-cycle clear so the new request is not lost.
  assign pending_d = (pending_q & ~clr_i) | (req_i & ~req_q);
  assign pending_o = pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      req_q     <= req_i;
      pending_q <= pending_d;
    end
  end
endmodule

module irq_pending_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_i,
  input  logic [3:0] mask_i,
  output logic [3:0] pend_o,
  input  logic [1:0] enc_y_i,
  input  logic       enc_valid_i,
  output logic       irq_o,
  output logic [1:0] irq_id_o,
  input  logic       ack_i,
  output logic       timeout_err_o
);
  localparam int NUM_LINES = 4;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_e;

  state_e         state_q;
  logic [7:0]     cnt_q;
  logic           irq_q;
  logic [1:0]     irq_id_q;
  logic           terr_q;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] clr;
  logic           to_hit;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    irq_pending_line u_line (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_i[i]),
      .clr_i     (clr[i]),
      .pending_o (pending[i])
    );
  end

  assign pend_o        = pending & mask_i;
  assign irq_o         = irq_q;
  assign irq_id_o      = irq_id_q;
  assign timeout_err_o = terr_q;
  assign to_hit        = (cnt_q == TO_LAST);

  // Service ends on ack or timeout; either way the serviced line is retired.
  always_comb begin
    clr = '0;
    if (state_q == S_ACTIVE && (ack_i || to_hit))
      clr[irq_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      irq_q    <= 1'b0;
      irq_id_q <= 2'd0;
      terr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          terr_q <= 1'b0;
          if (enc_valid_i) begin
            irq_id_q <= enc_y_i;
            cnt_q    <= 8'd0;
            irq_q    <= 1'b1;
            state_q  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (ack_i) begin
            irq_q   <= 1'b0;
            state_q <= S_GAP;
          end else if (to_hit) begin
            irq_q   <= 1'b0;
            terr_q  <= 1'b1;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          terr_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          terr_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a behavioural 4-input priority
// encoder closing the pend -> y/valid loop.

module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, mask, pend;
  logic [1:0] enc_y, irq_id;
  logic       enc_valid, irq, ack, terr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign enc_valid = |pend;
  assign enc_y     = pend[3] ? 2'd3 : pend[2] ? 2'd2 : pend[1] ? 2'd1 : 2'd0;

  irq_pending_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req),
    .mask_i        (mask),
    .pend_o        (pend),
    .enc_y_i       (enc_y),
    .enc_valid_i   (enc_valid),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .ack_i         (ack),
    .timeout_err_o (terr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 4'b0; mask = 4'hF; ack = 1'b0;
    step(); step();
    chk("rst_irq", {7'd0, irq}, 8'd0);
    chk("rst_id", {6'd0, irq_id}, 8'd0);
    chk("rst_terr", {7'd0, terr}, 8'd0);
    chk("rst_pend", {4'd0, pend}, 8'd0);
    reset = 1'b0;
    step();

    // single request, ack on third irq cycle
    req = 4'b0100; step();
    chk("s_pend", {4'd0, pend}, 8'h4);
    chk("s_irq_lat", {7'd0, irq}, 8'd0);
    req = 4'b0; step();
    chk("s_irq", {7'd0, irq}, 8'd1);
    chk("s_id", {6'd0, irq_id}, 8'd2);
    step(); step();
    chk("s_irq3", {7'd0, irq}, 8'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s_irq_fall", {7'd0, irq}, 8'd0);
    chk("s_pend_clr", {4'd0, pend}, 8'h0);
    chk("s_terr", {7'd0, terr}, 8'd0);
    step(); step();

    // priority order 3 then 1
    req = 4'b1010; step(); req = 4'b0;
    chk("p_pend", {4'd0, pend}, 8'hA);
    step();
    chk("p_irq1", {7'd0, irq}, 8'd1);
    chk("p_id1", {6'd0, irq_id}, 8'd3);
    ack = 1'b1; step(); ack = 1'b0;
    chk("p_low1", {7'd0, irq}, 8'd0);
    chk("p_pend1", {4'd0, pend}, 8'h2);
    step();
    chk("p_low2", {7'd0, irq}, 8'd0);
    step();
    chk("p_irq2", {7'd0, irq}, 8'd1);
    chk("p_id2", {6'd0, irq_id}, 8'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("p_fall2", {7'd0, irq}, 8'd0);
    chk("p_pend_end", {4'd0, pend}, 8'h0);
    step(); step();

    // masking hides line 3 until unmasked
    mask = 4'b0111; req = 4'b1001; step(); req = 4'b0;
    chk("m_pend", {4'd0, pend}, 8'h1);
    step();
    chk("m_id0", {6'd0, irq_id}, 8'd0);
    chk("m_irq0", {7'd0, irq}, 8'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("m_pend_hidden", {4'd0, pend}, 8'h0);
    step(); step();
    chk("m_no_irq", {7'd0, irq}, 8'd0);
    mask = 4'hF; #1;
    chk("m_unmask", {4'd0, pend}, 8'h8);
    step();
    chk("m_irq3", {7'd0, irq}, 8'd1);
    chk("m_id3", {6'd0, irq_id}, 8'd3);
    ack = 1'b1; step(); ack = 1'b0;
    chk("m_pend_end", {4'd0, pend}, 8'h0);
    step(); step();

    // timeout with no ack
    req = 4'b0001; step(); req = 4'b0; step();
    n = 0;
    while (irq && n < 10) begin n++; step(); end
    chk("t_len", 8'(n), 8'd4);
    chk("t_terr", {7'd0, terr}, 8'd1);
    step();
    chk("t_terr_pulse", {7'd0, terr}, 8'd0);
    chk("t_pend", {4'd0, pend}, 8'h0);
    step();

    // ack on the last allowed cycle beats the timeout
    req = 4'b0001; step(); req = 4'b0; step();
    chk("ta_irq", {7'd0, irq}, 8'd1);
    step(); step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("ta_fall", {7'd0, irq}, 8'd0);
    chk("ta_terr", {7'd0, terr}, 8'd0);
    chk("ta_pend", {4'd0, pend}, 8'h0);
    step(); step();

    // re-rise coinciding with clear keeps the line pending
    req = 4'b0010; step(); req = 4'b0; step();
    chk("r_id", {6'd0, irq_id}, 8'd1);
    ack = 1'b1; req = 4'b0010; step(); ack = 1'b0;
    chk("r_fall", {7'd0, irq}, 8'd0);
    chk("r_pend", {4'd0, pend}, 8'h2);
    step();
    chk("r_low", {7'd0, irq}, 8'd0);
    step();
    chk("r_irq", {7'd0, irq}, 8'd1);
    chk("r_id2", {6'd0, irq_id}, 8'd1);
    ack = 1'b1; req = 4'b0; step(); ack = 1'b0;
    chk("r_pend_end", {4'd0, pend}, 8'h0);
    step(); step();

    // no preemption by a higher request during service
    req = 4'b0001; step(); step();
    chk("np_id0", {6'd0, irq_id}, 8'd0);
    req = 4'b1001; step();
    chk("np_irq", {7'd0, irq}, 8'd1);
    chk("np_id_hold", {6'd0, irq_id}, 8'd0);
    chk("np_pend", {4'd0, pend}, 8'h9);
    ack = 1'b1; step(); ack = 1'b0; req = 4'b0;
    chk("np_pend2", {4'd0, pend}, 8'h8);
    step(); step();
    chk("np_id3", {6'd0, irq_id}, 8'd3);
    chk("np_irq3", {7'd0, irq}, 8'd1);
    ack = 1'b1; step(); ack = 1'b0;
    step(); step();

    // reset during ACTIVE, request line held high across release
    req = 4'b0110; step();
    chk("x_pend", {4'd0, pend}, 8'h6);
    step();
    chk("x_irq", {7'd0, irq}, 8'd1);
    req = 4'b0100; reset = 1'b1; step();
    chk("x_rst_irq", {7'd0, irq}, 8'd0);
    chk("x_rst_id", {6'd0, irq_id}, 8'd0);
    chk("x_rst_terr", {7'd0, terr}, 8'd0);
    chk("x_rst_pend", {4'd0, pend}, 8'h0);
    reset = 1'b0; step();
    chk("x_edge", {4'd0, pend}, 8'h4);
    step();
    chk("x_irq2", {7'd0, irq}, 8'd1);
    chk("x_id2", {6'd0, irq_id}, 8'd2);
    ack = 1'b1; step(); ack = 1'b0; req = 4'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
